axi4_lite_slave_regs: RTL and testbench

//  AXI4-Lite responder (slave) holding NUM_REGS AXI_WIDTH-bit control/status registers.

---
 rtl/axi4_lite_slave_regs.sv | 139 +++++++++++++
 tb/tb_axi4_lite_slave_regs.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite register-file responder: NUM_REGS x AXI_WIDTH control/status registers with write pulses.
// Optional macro AXIL_SLVERR_EN: addresses beyond the register window return SLVERR instead of aliasing.
module axi4_lite_slave_regs #(
   parameter int unsigned AXI_WIDTH = 32,
   parameter int unsigned AXI_DEPTH = 32,
   parameter int unsigned NUM_REGS  = 16
) (
   input  logic                          s_axi_aclk,
   input  logic                          s_axi_areset,
   input  logic                          s_axi_awvalid,
   output logic                          s_axi_awready,
   input  logic [AXI_DEPTH-1:0]          s_axi_awaddr,
   input  logic                          s_axi_wvalid,
   output logic                          s_axi_wready,
   input  logic [AXI_WIDTH-1:0]          s_axi_wdata,
   input  logic [AXI_WIDTH/8-1:0]        s_axi_wstrb,
   output logic                          s_axi_bvalid,
   input  logic                          s_axi_bready,
   output logic [1:0]                    s_axi_bresp,
   input  logic                          s_axi_arvalid,
   output logic                          s_axi_arready,
   input  logic [AXI_DEPTH-1:0]          s_axi_araddr,
   output logic                          s_axi_rvalid,
   input  logic                          s_axi_rready,
   output logic [AXI_WIDTH-1:0]          s_axi_rdata,
   output logic [1:0]                    s_axi_rresp,
   output logic [NUM_REGS*AXI_WIDTH-1:0] regs_o,
   output logic [NUM_REGS-1:0]           wr_pulse_o
);

   localparam int unsigned IDX_W     = $clog2(NUM_REGS);
   localparam int unsigned NUM_BYTES = AXI_WIDTH / 8;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   logic [NUM_REGS-1:0][AXI_WIDTH-1:0] regs;

   logic                 aw_held;
   logic [IDX_W-1:0]     aw_idx;
   logic                 aw_oor;
   logic                 w_held;
   logic [AXI_WIDTH-1:0] w_data;
   logic [NUM_BYTES-1:0] w_strb;

   logic             aw_hs_c;
   logic             w_hs_c;
   logic             ar_hs_c;
   logic             commit_c;
   logic             aw_oor_c;
   logic             ar_oor_c;
   logic [IDX_W-1:0] aw_idx_c;
   logic [IDX_W-1:0] ar_idx_c;
   logic             unused_addr_bits;

   // Readies follow the holding flags and stay low throughout reset.
   assign s_axi_awready = !aw_held && !s_axi_areset;
   assign s_axi_wready  = !w_held && !s_axi_areset;
   assign s_axi_arready = !s_axi_rvalid && !s_axi_areset;

   assign aw_hs_c  = s_axi_awvalid && s_axi_awready;
   assign w_hs_c   = s_axi_wvalid && s_axi_wready;
   assign ar_hs_c  = s_axi_arvalid && s_axi_arready;
   assign commit_c = aw_held && w_held && (!s_axi_bvalid || s_axi_bready);

   assign aw_idx_c = s_axi_awaddr[IDX_W+1:2];
   assign ar_idx_c = s_axi_araddr[IDX_W+1:2];

`ifdef AXIL_SLVERR_EN
   assign aw_oor_c         = |s_axi_awaddr[AXI_DEPTH-1:IDX_W+2];
   assign ar_oor_c         = |s_axi_araddr[AXI_DEPTH-1:IDX_W+2];
   assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
`else
   // Upper address bits alias onto the register window.
   assign aw_oor_c         = 1'b0;
   assign ar_oor_c         = 1'b0;
   assign unused_addr_bits = ^{s_axi_awaddr[AXI_DEPTH-1:IDX_W+2], s_axi_awaddr[1:0],
                               s_axi_araddr[AXI_DEPTH-1:IDX_W+2], s_axi_araddr[1:0]};
`endif

   assign regs_o = regs;

   // Write path: independent AW/W holding slots, commit once both are full and B can accept.
   always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
      if (s_axi_areset) begin
         regs         <= '0;
         aw_held      <= 1'b0;
         aw_idx       <= '0;
         aw_oor       <= 1'b0;
         w_held       <= 1'b0;
         w_data       <= '0;
         w_strb       <= '0;
         s_axi_bvalid <= 1'b0;
         s_axi_bresp  <= RESP_OKAY;
         wr_pulse_o   <= '0;
      end else begin
         wr_pulse_o <= '0;
         if (commit_c) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= aw_oor ? RESP_SLVERR : RESP_OKAY;
            if (!aw_oor) begin
               for (int unsigned b = 0; b < NUM_BYTES; b++) begin
                  if (w_strb[b]) regs[aw_idx][b*8 +: 8] <= w_data[b*8 +: 8];
               end
               wr_pulse_o[aw_idx] <= 1'b1;
            end
         end else if (s_axi_bvalid && s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
         end
         if (aw_hs_c) begin
            aw_held <= 1'b1;
            aw_idx  <= aw_idx_c;
            aw_oor  <= aw_oor_c;
         end
         if (w_hs_c) begin
            w_held <= 1'b1;
            w_data <= s_axi_wdata;
            w_strb <= s_axi_wstrb;
         end
      end
   end

   // Read path: data captured on the AR handshake edge sees the pre-commit register value.
   always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
      if (s_axi_areset) begin
         s_axi_rvalid <= 1'b0;
         s_axi_rdata  <= '0;
         s_axi_rresp  <= RESP_OKAY;
      end else if (ar_hs_c) begin
         s_axi_rvalid <= 1'b1;
         s_axi_rdata  <= ar_oor_c ? '0 : regs[ar_idx_c];
         s_axi_rresp  <= ar_oor_c ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi_rvalid && s_axi_rready) begin
         s_axi_rvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Self-checking bench for axi4_lite_slave_regs: vector table, corner-case sequences, random traffic vs model.
`timescale 1ns/1ps
module tb_axi4_lite_slave_regs;

   localparam int unsigned NREG   = 16;
   localparam int unsigned BUDGET = 64;
`ifdef AXIL_SLVERR_EN
   localparam bit SLVERR_EN = 1'b1;
`else
   localparam bit SLVERR_EN = 1'b0;
`endif

   logic                 s_axi_aclk = 1'b0;
   logic                 s_axi_areset = 1'b1;
   logic                 s_axi_awvalid = 1'b0;
   logic                 s_axi_awready;
   logic [31:0]          s_axi_awaddr = '0;
   logic                 s_axi_wvalid = 1'b0;
   logic                 s_axi_wready;
   logic [31:0]          s_axi_wdata = '0;
   logic [3:0]           s_axi_wstrb = '0;
   logic                 s_axi_bvalid;
   logic                 s_axi_bready = 1'b0;
   logic [1:0]           s_axi_bresp;
   logic                 s_axi_arvalid = 1'b0;
   logic                 s_axi_arready;
   logic [31:0]          s_axi_araddr = '0;
   logic                 s_axi_rvalid;
   logic                 s_axi_rready = 1'b0;
   logic [31:0]          s_axi_rdata;
   logic [1:0]           s_axi_rresp;
   logic [NREG*32-1:0]   regs_o;
   logic [NREG-1:0]      wr_pulse_o;

   axi4_lite_slave_regs #(.AXI_WIDTH(32), .AXI_DEPTH(32), .NUM_REGS(NREG)) dut (
      .s_axi_aclk(s_axi_aclk), .s_axi_areset(s_axi_areset),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
      .s_axi_wstrb(s_axi_wstrb),
      .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
      .s_axi_rresp(s_axi_rresp),
      .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
   );

   always #5 s_axi_aclk = ~s_axi_aclk;

   int total = 0;
   int bad = 0;
   int exp_pulses = 0;
   int seen_pulses = 0;
   logic [31:0] model [NREG];

   always @(posedge s_axi_aclk) seen_pulses <= seen_pulses + $countones(wr_pulse_o);

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          idx;
      logic [31:0] exp_reg;
      logic [1:0]  exp_resp;
      logic [15:0] exp_pulse;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] dut_reg(input int i);
      return regs_o[i*32 +: 32];
   endfunction

   // Reference model: register window of NREG words, byte-strobed writes.
   function automatic bit is_oor(input logic [31:0] a);
      return SLVERR_EN && (a[31:6] != 26'd0);
   endfunction

   function automatic int idx_of(input logic [31:0] a);
      return int'(a[5:2]);
   endfunction

   function automatic logic [15:0] model_pulse(input logic [31:0] a);
      return is_oor(a) ? 16'h0 : (16'h1 << idx_of(a));
   endfunction

   function automatic logic [1:0] model_resp(input logic [31:0] a);
      return is_oor(a) ? 2'b10 : 2'b00;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      return is_oor(a) ? 32'h0 : model[idx_of(a)];
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      if (!is_oor(a)) begin
         for (int b = 0; b < 4; b++)
            if (s[b]) model[idx_of(a)][b*8 +: 8] = d[b*8 +: 8];
         exp_pulses++;
      end
   endtask

   task automatic tick();
      @(posedge s_axi_aclk);
      #1;
   endtask

   task automatic chan_aw(input logic [31:0] a, input int dly);
      logic hs = 1'b0;
      repeat (dly) tick();
      s_axi_awaddr = a;
      s_axi_awvalid = 1'b1;
      for (int k = 0; k < BUDGET && !hs; k++) begin
         hs = s_axi_awready;
         tick();
      end
      s_axi_awvalid = 1'b0;
      check("aw_handshake", 32'(hs), 32'd1);
   endtask

   task automatic chan_w(input logic [31:0] d, input logic [3:0] s, input int dly);
      logic hs = 1'b0;
      repeat (dly) tick();
      s_axi_wdata = d;
      s_axi_wstrb = s;
      s_axi_wvalid = 1'b1;
      for (int k = 0; k < BUDGET && !hs; k++) begin
         hs = s_axi_wready;
         tick();
      end
      s_axi_wvalid = 1'b0;
      check("w_handshake", 32'(hs), 32'd1);
   endtask

   task automatic chan_ar(input logic [31:0] a, input int dly);
      logic hs = 1'b0;
      repeat (dly) tick();
      s_axi_araddr = a;
      s_axi_arvalid = 1'b1;
      for (int k = 0; k < BUDGET && !hs; k++) begin
         hs = s_axi_arready;
         tick();
      end
      s_axi_arvalid = 1'b0;
      check("ar_handshake", 32'(hs), 32'd1);
   endtask

   task automatic wait_b(input int dly, output logic [1:0] resp);
      logic ok = 1'b0;
      resp = 2'b11;
      repeat (dly) begin
         check("b_hold_valid", 32'(s_axi_bvalid), 32'd1);
         tick();
      end
      s_axi_bready = 1'b1;
      for (int k = 0; k < BUDGET && !ok; k++) begin
         ok = s_axi_bvalid;
         resp = s_axi_bresp;
         tick();
      end
      s_axi_bready = 1'b0;
      check("b_handshake", 32'(ok), 32'd1);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly,
                           input logic [15:0] exp_pulse, input logic [1:0] exp_resp, input string tag);
      logic [1:0] resp;
      fork
         chan_aw(a, aw_dly);
         chan_w(d, s, w_dly);
      join
      tick();
      check({tag, "_pulse"}, 32'(wr_pulse_o), 32'(exp_pulse));
      check({tag, "_bvalid"}, 32'(s_axi_bvalid), 32'd1);
      model_write(a, d, s);
      wait_b(b_dly, resp);
      check({tag, "_bresp"}, 32'(resp), 32'(exp_resp));
      check({tag, "_bdone"}, 32'(s_axi_bvalid), 32'd0);
      check({tag, "_pulse_off"}, 32'(wr_pulse_o), 32'd0);
   endtask

   task automatic do_read(input logic [31:0] a, input int ar_dly, input int r_dly,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp, input string tag);
      chan_ar(a, ar_dly);
      check({tag, "_rvalid"}, 32'(s_axi_rvalid), 32'd1);
      check({tag, "_rdata"}, s_axi_rdata, exp_data);
      check({tag, "_rresp"}, 32'(s_axi_rresp), 32'(exp_resp));
      repeat (r_dly) begin
         tick();
         check({tag, "_rhold"}, s_axi_rdata, exp_data);
         check({tag, "_arready_low"}, 32'(s_axi_arready), 32'd0);
      end
      s_axi_rready = 1'b1;
      tick();
      s_axi_rready = 1'b0;
      check({tag, "_rdone"}, 32'(s_axi_rvalid), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_readies"}, 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd0);
      check({tag, "_valids"}, 32'({s_axi_bvalid, s_axi_rvalid}), 32'd0);
      check({tag, "_resps"}, 32'({s_axi_bresp, s_axi_rresp}), 32'd0);
      check({tag, "_rdata"}, s_axi_rdata, 32'd0);
      check({tag, "_regs"}, 32'(|regs_o), 32'd0);
      check({tag, "_pulse"}, 32'(wr_pulse_o), 32'd0);
   endtask

   vec_t vecs [7];

   initial begin
      logic [1:0]  resp;
      logic [31:0] pre;

      for (int i = 0; i < int'(NREG); i++) model[i] = 32'h0;
      vecs[0] = '{32'h08, 32'hDEADBEEF, 4'hF, 2,  32'hDEADBEEF, 2'b00, 16'h0004};
      vecs[1] = '{32'h08, 32'h000000AA, 4'h1, 2,  32'hDEADBEAA, 2'b00, 16'h0004};
      vecs[2] = '{32'h0C, 32'h12345678, 4'h6, 3,  32'h00345600, 2'b00, 16'h0008};
      vecs[3] = '{32'h3C, 32'hFFFFFFFF, 4'h8, 15, 32'hFF000000, 2'b00, 16'h8000};
      vecs[4] = '{32'h0D, 32'hAABBCCDD, 4'h0, 3,  32'h00345600, 2'b00, 16'h0008};
`ifdef AXIL_SLVERR_EN
      vecs[5] = '{32'h40, 32'h11223344, 4'hF, 0,  32'h00000000, 2'b10, 16'h0000};
`else
      vecs[5] = '{32'h40, 32'h11223344, 4'hF, 0,  32'h11223344, 2'b00, 16'h0001};
`endif
      vecs[6] = '{32'h0E, 32'hCAFEF00D, 4'h9, 3,  32'hCA34560D, 2'b00, 16'h0008};

      // Reset state, then release
      repeat (3) tick();
      check_all_zero("rst_init");
      s_axi_areset = 1'b0;
      tick();
      check("rst_release_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd7);

      // Vector table: write, check register view, read back
      for (int i = 0; i < 7; i++) begin
         do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, i % 3, (2 * i) % 3, i % 2,
                  vecs[i].exp_pulse, vecs[i].exp_resp, "vec_wr");
         check("vec_reg", dut_reg(vecs[i].idx), vecs[i].exp_reg);
         do_read(32'(vecs[i].idx) << 2, 0, i % 3, vecs[i].exp_reg, 2'b00, "vec_rd");
      end

      // W arrives three cycles before AW
      chan_w(32'h00001100, 4'h2, 0);
      repeat (3) begin
         tick();
         check("wfirst_wready_low", 32'(s_axi_wready), 32'd0);
         check("wfirst_no_b", 32'(s_axi_bvalid), 32'd0);
      end
      chan_aw(32'h08, 0);
      tick();
      check("wfirst_pulse", 32'(wr_pulse_o), 32'h0004);
      model_write(32'h08, 32'h00001100, 4'h2);
      wait_b(0, resp);
      check("wfirst_bresp", 32'(resp), 32'd0);
      check("wfirst_wready_back", 32'(s_axi_wready), 32'd1);
      do_read(32'h08, 0, 0, 32'hDEAD11AA, 2'b00, "wfirst_rd");

      // B held off while a second write is captured but not committed
      fork
         chan_aw(32'h10, 0);
         chan_w(32'h11111111, 4'hF, 0);
      join
      tick();
      check("bstall_pulse1", 32'(wr_pulse_o), 32'h0010);
      model_write(32'h10, 32'h11111111, 4'hF);
      pre = model[5];
      fork
         chan_aw(32'h14, 0);
         chan_w(32'h22222222, 4'hF, 0);
      join
      check("bstall_held", 32'({s_axi_awready, s_axi_wready}), 32'd0);
      repeat (4) begin
         check("bstall_bvalid", 32'(s_axi_bvalid), 32'd1);
         check("bstall_bresp", 32'(s_axi_bresp), 32'd0);
         check("bstall_no_pulse", 32'(wr_pulse_o), 32'd0);
         check("bstall_reg5_old", dut_reg(5), pre);
         tick();
      end
      s_axi_bready = 1'b1;
      tick();
      check("bstall_commit_pulse", 32'(wr_pulse_o), 32'h0020);
      check("bstall_reg5_new", dut_reg(5), 32'h22222222);
      check("bstall_b_again", 32'(s_axi_bvalid), 32'd1);
      model_write(32'h14, 32'h22222222, 4'hF);
      tick();
      s_axi_bready = 1'b0;
      check("bstall_b_drained", 32'(s_axi_bvalid), 32'd0);

      // Read stall with a same-edge write to the register being read
      s_axi_bready = 1'b1;
      s_axi_awaddr = 32'h14; s_axi_wdata = 32'h33333333; s_axi_wstrb = 4'hF;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      tick();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      s_axi_araddr = 32'h14; s_axi_arvalid = 1'b1;
      check("rstall_arready", 32'(s_axi_arready), 32'd1);
      pre = model[5];
      tick();
      s_axi_arvalid = 1'b0;
      check("rstall_rvalid", 32'(s_axi_rvalid), 32'd1);
      check("rstall_pre_value", s_axi_rdata, pre);
      check("rstall_pulse", 32'(wr_pulse_o), 32'h0020);
      model_write(32'h14, 32'h33333333, 4'hF);
      repeat (4) begin
         tick();
         check("rstall_hold_valid", 32'(s_axi_rvalid), 32'd1);
         check("rstall_hold_data", s_axi_rdata, 32'h22222222);
         check("rstall_arready_low", 32'(s_axi_arready), 32'd0);
      end
      s_axi_bready = 1'b0;
      s_axi_rready = 1'b1;
      tick();
      s_axi_rready = 1'b0;
      check("rstall_rdone", 32'(s_axi_rvalid), 32'd0);
      check("rstall_bdone", 32'(s_axi_bvalid), 32'd0);
      do_read(32'h14, 0, 1, 32'h33333333, 2'b00, "rstall_rd");

      // Random traffic against the model
      for (int n = 0; n < 150; n++) begin
         logic [31:0] a;
         a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(6, 31));
         if ($urandom_range(0, 1) == 1)
            do_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), model_pulse(a), model_resp(a), "rnd_wr");
         else
            do_read(a, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                    model_read(a), model_resp(a), "rnd_rd");
      end
      repeat (2) tick();
      for (int i = 0; i < int'(NREG); i++) check("rnd_final_reg", dut_reg(i), model[i]);
      check("pulse_count", 32'(seen_pulses), 32'(exp_pulses));

      // Reset mid-transaction: held W and pending R are discarded
      chan_w(32'h55555555, 4'hF, 0);
      chan_ar(32'h08, 0);
      #2;
      s_axi_areset = 1'b1;
      #1;
      check_all_zero("rst_mid");
      tick();
      tick();
      s_axi_areset = 1'b0;
      #1;
      check("rst_mid_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd7);
      for (int i = 0; i < int'(NREG); i++) model[i] = 32'h0;
      tick();
      chan_aw(32'h18, 0);
      repeat (3) begin
         tick();
         check("rst_mid_no_commit", 32'(s_axi_bvalid), 32'd0);
         check("rst_mid_reg6_zero", dut_reg(6), 32'd0);
      end
      chan_w(32'h66666666, 4'hF, 0);
      tick();
      check("rst_mid_pulse", 32'(wr_pulse_o), 32'h0040);
      model_write(32'h18, 32'h66666666, 4'hF);
      wait_b(0, resp);
      check("rst_mid_bresp", 32'(resp), 32'd0);
      check("rst_mid_reg6", dut_reg(6), 32'h66666666);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
